pc_gen: RTL and testbench

Parametrised program-counter generator for the instruction-fetch stage.
- Produces the fetch address and chip-enable for instruction memory.
- Advances sequentially, or redirects on a branch/jump or on a pipeline flush (exception or eret).
- Holds the PC on pipeline stall or when the fetch port is not ready. A branch arriving during a hold is buffered so it is never lost.

---
 rtl/pc_gen.sv | 82 ++++++++
 tb/tb_pc_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator for the instruction-fetch stage: sequential advance,
// branch/flush redirect, and a one-entry buffer that keeps branches seen during a hold.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redir_pend,
  output logic              pc_misalign
);

  // State is {ce, redir_pend}: OFF = 2'b00, RUN = 2'b10, HOLD = 2'b11.
  // Both bits are module outputs, so the state is directly observable.
  localparam logic [1:0] ST_OFF  = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_HOLD = 2'b11;

  // Handshake: a fetch request (pc, ce) is accepted on an edge where ce=1 and
  // if_ready=1; unless stalled, the pc then moves on. Holding is otherwise free.
  logic              advance;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] buf_target;
  logic [ADDR_W-1:0] buf_next;
  logic [1:0]        state_next;
  logic              misalign_next;

  assign advance = ce & ~stall & if_ready;

  always_comb begin
    pc_next    = pc;
    buf_next   = buf_target;
    state_next = {ce, redir_pend};
    if (!ce) begin
      pc_next    = RESET_VEC;
      state_next = ST_RUN;
    end else if (flush) begin
      pc_next    = flush_pc;
      state_next = ST_RUN;
    end else if (advance && branch_flag) begin
      // A fresh branch supersedes anything still buffered.
      pc_next    = branch_target;
      state_next = ST_RUN;
    end else if (advance && redir_pend) begin
      pc_next    = buf_target;
      state_next = ST_RUN;
    end else if (advance) begin
      pc_next    = pc + ADDR_W'(INST_BYTES);
    end else if (branch_flag) begin
      buf_next   = branch_target;
      state_next = ST_HOLD;
    end
  end

  assign misalign_next = (INST_BYTES == 4) && (pc_next[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_VEC;
      ce          <= ST_OFF[1];
      redir_pend  <= ST_OFF[0];
      buf_target  <= '0;
      pc_misalign <= 1'b0;
    end else begin
      pc          <= pc_next;
      ce          <= state_next[1];
      redir_pend  <= state_next[0];
      buf_target  <= buf_next;
      pc_misalign <= misalign_next;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios from the fetch-stage rules
// plus a randomized run compared against a queue-based reference model.
module tb_pc_gen;

  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic          branch_flag;
  logic [AW-1:0] branch_target;
  logic          if_ready;
  logic [AW-1:0] pc;
  logic          ce;
  logic          redir_pend;
  logic          pc_misalign;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural pc, enable, and the set of waiting targets.
  logic [AW-1:0] m_pc;
  logic          m_ce;
  logic          m_mis;
  logic [AW-1:0] pend_q[$];

  pc_gen #(.ADDR_W(AW), .RESET_VEC(32'h0), .INST_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target(branch_target), .if_ready(if_ready),
    .pc(pc), .ce(ce), .redir_pend(redir_pend), .pc_misalign(pc_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_edge();
    bit adv;
    if (rst) begin
      m_ce = 1'b0;
      m_pc = '0;
      pend_q.delete();
    end else if (!m_ce) begin
      m_ce = 1'b1;
      m_pc = '0;
    end else begin
      adv = !stall && if_ready;
      if (flush) begin
        m_pc = flush_pc;
        pend_q.delete();
      end else if (adv && branch_flag) begin
        m_pc = branch_target;
        pend_q.delete();
      end else if (adv && pend_q.size() > 0) begin
        m_pc = pend_q.pop_front();
      end else if (adv) begin
        m_pc = m_pc + 32'd4;
      end else if (branch_flag) begin
        pend_q.delete();
        pend_q.push_back(branch_target);
      end
    end
    m_mis = m_ce && (m_pc % 4 != 0);
  endtask

  // Inputs change only at the negedge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; flush_pc = '0; branch_flag = 0; branch_target = '0; if_ready = 1;
  endtask

  task automatic goto_pc(input logic [AW-1:0] addr);
    flush = 1; flush_pc = addr;
    tick();
    flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ce !== 1'b0 || pc !== 32'h0 || redir_pend !== 1'b0 || pc_misalign !== 1'b0)
        $display("FAIL reset_hold: got ce=%b pc=%h pend=%b mis=%b expected ce=0 pc=0 pend=0 mis=0",
                 ce, pc, redir_pend, pc_misalign);
      else n_pass++;
    end
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (ce !== 1'b1 || pc !== 32'(i * 4))
        $display("FAIL reset_release c%0d: got ce=%b pc=%h expected ce=1 pc=%h", i, ce, pc, 32'(i * 4));
      else n_pass++;
    end
  endtask

  task automatic test_stall_wrap();
    logic [AW-1:0] exp_pc[4] = '{32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
    goto_pc(32'hFFFFFFF8);
    n_checks++;
    if (pc !== 32'hFFFFFFF8) $display("FAIL wrap_setup: got pc=%h expected pc=fffffff8", pc);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      stall = (i < 2);
      tick();
      n_checks++;
      if (pc !== exp_pc[i] || pc_misalign !== 1'b0)
        $display("FAIL stall_wrap c%0d: got pc=%h mis=%b expected pc=%h mis=0", i, pc, pc_misalign, exp_pc[i]);
      else n_pass++;
    end
    stall = 0;
  endtask

  task automatic test_branch_stall();
    goto_pc(32'h100);
    stall = 1; branch_flag = 1; branch_target = 32'h400;
    tick();
    branch_flag = 0; branch_target = 32'h0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pc !== 32'h100 || redir_pend !== 1'b1)
        $display("FAIL branch_stall_hold c%0d: got pc=%h pend=%b expected pc=100 pend=1", i, pc, redir_pend);
      else n_pass++;
      if (i < 2) tick();
    end
    stall = 0;
    tick();
    n_checks++;
    if (pc !== 32'h400 || redir_pend !== 1'b0)
      $display("FAIL branch_stall_release: got pc=%h pend=%b expected pc=400 pend=0", pc, redir_pend);
    else n_pass++;
    tick();
    n_checks++;
    if (pc !== 32'h404) $display("FAIL branch_stall_next: got pc=%h expected pc=404", pc);
    else n_pass++;
  endtask

  task automatic test_flush_priority();
    goto_pc(32'h100);
    stall = 1; branch_flag = 1; branch_target = 32'h400;
    tick();
    branch_flag = 0;
    flush = 1; flush_pc = 32'h80000180;
    tick();
    flush = 0;
    n_checks++;
    if (pc !== 32'h80000180 || redir_pend !== 1'b0)
      $display("FAIL flush_priority: got pc=%h pend=%b expected pc=80000180 pend=0", pc, redir_pend);
    else n_pass++;
    stall = 0;
    tick();
    n_checks++;
    if (pc !== 32'h80000184) $display("FAIL flush_release: got pc=%h expected pc=80000184", pc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // Fresh branch beats the buffered one.
    goto_pc(32'h100);
    stall = 1; branch_flag = 1; branch_target = 32'h400;
    tick();
    stall = 0; branch_target = 32'h800;
    tick();
    branch_flag = 0;
    n_checks++;
    if (pc !== 32'h800 || redir_pend !== 1'b0)
      $display("FAIL fresh_beats_pending: got pc=%h pend=%b expected pc=800 pend=0", pc, redir_pend);
    else n_pass++;
    // Later branch during a not-ready hold overwrites the buffer.
    if_ready = 0; branch_flag = 1; branch_target = 32'h500;
    tick();
    branch_target = 32'h600;
    tick();
    branch_flag = 0;
    n_checks++;
    if (pc !== 32'h800 || redir_pend !== 1'b1)
      $display("FAIL not_ready_hold: got pc=%h pend=%b expected pc=800 pend=1", pc, redir_pend);
    else n_pass++;
    if_ready = 1;
    tick();
    n_checks++;
    if (pc !== 32'h600 || redir_pend !== 1'b0)
      $display("FAIL buffer_overwrite: got pc=%h pend=%b expected pc=600 pend=0", pc, redir_pend);
    else n_pass++;
  endtask

  task automatic test_misalign_reset();
    branch_flag = 1; branch_target = 32'h202;
    tick();
    branch_flag = 0;
    n_checks++;
    if (pc !== 32'h202 || pc_misalign !== 1'b1)
      $display("FAIL misalign: got pc=%h mis=%b expected pc=202 mis=1", pc, pc_misalign);
    else n_pass++;
    stall = 1; branch_flag = 1; branch_target = 32'h300;
    tick();
    branch_flag = 0; stall = 0;
    rst = 1;
    tick();
    n_checks++;
    if (ce !== 1'b0 || pc !== 32'h0 || pc_misalign !== 1'b0 || redir_pend !== 1'b0)
      $display("FAIL mid_reset: got ce=%b pc=%h mis=%b pend=%b expected ce=0 pc=0 mis=0 pend=0",
               ce, pc, pc_misalign, redir_pend);
    else n_pass++;
    // Redirects are ignored on the enable edge.
    rst = 0; flush = 1; flush_pc = 32'hDEAD0000; branch_flag = 1; branch_target = 32'h900;
    tick();
    flush = 0; branch_flag = 0;
    n_checks++;
    if (ce !== 1'b1 || pc !== 32'h0 || redir_pend !== 1'b0)
      $display("FAIL ce_edge_ignore: got ce=%b pc=%h pend=%b expected ce=1 pc=0 pend=0", ce, pc, redir_pend);
    else n_pass++;
    tick();
    n_checks++;
    if (pc !== 32'h4) $display("FAIL reset_discards_pending: got pc=%h expected pc=4", pc);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      flush_pc      = $urandom & 32'hFFFFFFFC;
      branch_flag   = ($urandom_range(0, 3) == 0);
      branch_target = $urandom;
      if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
      if_ready      = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (pc !== m_pc || ce !== m_ce || redir_pend !== (pend_q.size() != 0) || pc_misalign !== m_mis) begin
        if (errs < 10)
          $display("FAIL random c%0d: got pc=%h ce=%b pend=%b mis=%b expected pc=%h ce=%b pend=%b mis=%b",
                   i, pc, ce, redir_pend, pc_misalign, m_pc, m_ce, pend_q.size() != 0, m_mis);
        errs++;
      end else n_pass++;
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_pc = '0; m_ce = 1'b0; m_mis = 1'b0;
    @(negedge clk);
    test_reset();
    test_stall_wrap();
    test_branch_stall();
    test_flush_priority();
    test_back_to_back();
    test_misalign_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
